// File: rtl/tst_sig_sched_if.sv
// Register port, run control and strobe outputs of the B700 timing-strobe scheduler.
interface tst_sig_sched_if #(
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_data;
    logic             start;
    logic             stop;
    logic             TNO;
    logic             TNC;
    logic             TNI;
    logic             TKI;
    logic             TNP;
    logic             TKP;
    logic             upr1;
    logic             upr2;
    logic             upr3;
    logic             busy;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, stop,
        input  TNO, TNC, TNI, TKI, TNP, TKP, upr1, upr2, upr3, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, stop,
        output TNO, TNC, TNI, TKI, TNP, TKP, upr1, upr2, upr3, busy
    );
endinterface

// File: rtl/tst_sig_sched.sv
// Timing-strobe scheduler: period counter, frame counter and window decodes, all outputs registered.
// Strobes lag cnt by one cycle; config is staged and only applied at period/frame boundaries.
module tst_sig_sched #(
    parameter int CNT_W = 16,
    parameter int FRM_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    tst_sig_sched_if.slave bus
);
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [FRM_W-1:0] frm_t;

    typedef struct packed {
        cnt_t p;
        cnt_t ti_start;
        cnt_t ti_end;
        cnt_t tp_start;
        cnt_t tp_end;
        frm_t n;
    } sched_cfg_t;

    localparam sched_cfg_t CFG_DEFAULT = '{
        p:        cnt_t'(1000),
        ti_start: cnt_t'(10),
        ti_end:   cnt_t'(200),
        tp_start: cnt_t'(300),
        tp_end:   cnt_t'(900),
        n:        frm_t'(1)
    };

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t     state;
    cnt_t       cnt;
    frm_t       frm;
    sched_cfg_t stg;
    sched_cfg_t stg_nxt;
    sched_cfg_t act;
    logic [2:0] stg_mode;
    logic [2:0] stg_mode_nxt;
    logic [2:0] mode_act;
    cnt_t       p_eff;
    frm_t       n_eff;
    logic       running;
    logic       per_wrap;
    logic       frm_wrap;

    // Copies take the post-write staging value so a write on the wrap cycle is not lost.
    always_comb begin
        stg_nxt      = stg;
        stg_mode_nxt = stg_mode;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                3'd0:    stg_nxt.p        = bus.cfg_data;
                3'd1:    stg_nxt.ti_start = bus.cfg_data;
                3'd2:    stg_nxt.ti_end   = bus.cfg_data;
                3'd3:    stg_nxt.tp_start = bus.cfg_data;
                3'd4:    stg_nxt.tp_end   = bus.cfg_data;
                3'd5:    stg_nxt.n        = bus.cfg_data[FRM_W-1:0];
                3'd6:    stg_mode_nxt     = bus.cfg_data[2:0];
                default: ;
            endcase
        end
    end

    assign p_eff    = (act.p < cnt_t'(2)) ? cnt_t'(2) : act.p;
    assign n_eff    = (act.n == '0) ? frm_t'(1) : act.n;
    assign running  = (state != IDLE);
    assign per_wrap = running && (cnt == p_eff - cnt_t'(1));
    // >= rather than == so a shrunk N cannot strand frm above the new limit.
    assign frm_wrap = per_wrap && (frm >= n_eff - frm_t'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            frm      <= '0;
            stg      <= CFG_DEFAULT;
            act      <= CFG_DEFAULT;
            stg_mode <= '0;
            mode_act <= '0;
            bus.TNO  <= 1'b0;
            bus.TNC  <= 1'b0;
            bus.TNI  <= 1'b0;
            bus.TKI  <= 1'b0;
            bus.TNP  <= 1'b0;
            bus.TKP  <= 1'b0;
            bus.upr1 <= 1'b0;
            bus.upr2 <= 1'b0;
            bus.upr3 <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            stg      <= stg_nxt;
            stg_mode <= stg_mode_nxt;

            bus.TNC  <= running && (cnt == '0);
            bus.TNO  <= running && (cnt == '0) && (frm == '0);
            bus.TNI  <= running && (cnt == act.ti_start);
            bus.TKI  <= running && (cnt == act.ti_end);
            bus.TNP  <= running && (cnt == act.tp_start);
            bus.TKP  <= running && (cnt == act.tp_end);
            bus.busy <= running;
            bus.upr1 <= mode_act[2];
            bus.upr2 <= mode_act[1];
            bus.upr3 <= mode_act[0];

            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state    <= RUN;
                        cnt      <= '0;
                        frm      <= '0;
                        act      <= stg_nxt;
                        mode_act <= stg_mode_nxt;
                    end
                end
                RUN, STOPPING: begin
                    if (per_wrap) begin
                        cnt <= '0;
                        frm <= frm_wrap ? '0 : frm + frm_t'(1);
                        act <= stg_nxt;
                        if (frm_wrap) begin
                            mode_act <= stg_mode_nxt;
                        end
                        // A stop landing on the last cycle ends here: no TNC for the next period.
                        if (state == STOPPING || bus.stop) begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                        if (bus.stop) begin
                            state <= STOPPING;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
